// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared single-cycle ALU.
// One operation in flight: accept, execute, then hold the response until taken.
module alu_arbiter #(
    parameter int XLEN = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            r0_valid,
    output logic            r0_ready,
    input  logic [XLEN-1:0] r0_a,
    input  logic [XLEN-1:0] r0_b,
    input  logic [3:0]      r0_op,
    input  logic            r1_valid,
    output logic            r1_ready,
    input  logic [XLEN-1:0] r1_a,
    input  logic [XLEN-1:0] r1_b,
    input  logic [3:0]      r1_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_zero,
    output logic            busy,
    output logic [CNTW-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    state_t          state_next;
    logic            ptr;
    logic            owner;
    logic            gnt_any;
    logic            gnt_id;
    logic            accept;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [3:0]      opc;

    always_comb begin
        gnt_any    = r0_valid | r1_valid;
        gnt_id     = (r0_valid && r1_valid) ? ptr : r1_valid;
        r0_ready   = 1'b0;
        r1_ready   = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (gnt_any && !reset) begin
                    r0_ready   = !gnt_id;
                    r1_ready   = gnt_id;
                    state_next = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign accept    = r0_ready | r1_ready;
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign alu_a     = opa;
    assign alu_b     = opb;
    assign alu_ctrl  = opc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= 1'b0;
            owner      <= 1'b0;
            opa        <= '0;
            opb        <= '0;
            opc        <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opa   <= gnt_id ? r1_a : r0_a;
                        opb   <= gnt_id ? r1_b : r0_b;
                        opc   <= gnt_id ? r1_op : r0_op;
                        owner <= gnt_id;
                        ptr   <= ~gnt_id;
                    end
                end
                EXEC: begin
                    // SUB reporting zero leaves the ALU result undefined
                    if (opc == 4'b0110 && alu_zero) begin
                        rsp_result <= '0;
                    end else begin
                        rsp_result <= alu_result;
                    end
                    rsp_zero <= alu_zero;
                    rsp_id   <= owner;
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count <= op_count + CNTW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
